// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard/stall controller for the 5-stage MIPS pipeline. It decodes the
//   instruction in D and keeps a shadow pipeline of destination register and
//   Tnew for the E, M and W stages. From these it computes:
//     - the stall / E-bubble request (PC and D hold, E is loaded with a bubble)
//     - forwarding selects for the D-stage comparators, the E-stage ALU
//       inputs and the M-stage store data.
//
// Parameters:
//   W_FWD_D    1: D-stage selects may pick the W source (sel 3)
//              0: register file writes through internally, sel 3 never used
//
// Optional feature macro:
//   HAZARD_STALL_CNT_EN  builds a 32-bit wrapping stall-cycle counter;
//                        without it stall_cnt is tied to 0.
//
// Ports:
//   clk        in   1  clock
//   reset      in   1  synchronous, active-high reset
//   ir_d       in  32  instruction currently in D
//   stall      out  1  freeze PC and D register this cycle
//   ir_e_clr   out  1  E register loads a bubble at next edge (== stall)
//   fwd_rs_d   out  2  D rs source: 0 RF, 1 E (PC8_E), 2 M, 3 W
//   fwd_rt_d   out  2  D rt source, same encoding
//   fwd_rs_e   out  2  E rs source: 0 V1_E, 1 M, 2 W
//   fwd_rt_e   out  2  E rt source: 0 V2_E, 1 M, 2 W
//   fwd_rt_m   out  1  M store data: 0 pipelined value, 1 W
//   stall_cnt  out 32  stall-cycle counter
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned W_FWD_D = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  output logic        stall,
  output logic        ir_e_clr,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m,
  output logic [31:0] stall_cnt
);

  // Instruction fields
  logic [5:0] w_op, w_funct;
  logic [4:0] w_rs, w_rt, w_rd;
  assign w_op    = ir_d[31:26];
  assign w_rs    = ir_d[25:21];
  assign w_rt    = ir_d[20:16];
  assign w_rd    = ir_d[15:11];
  assign w_funct = ir_d[5:0];

  // The shamt field plays no part in hazard detection.
  logic w_unused_shamt;
  assign w_unused_shamt = ^ir_d[10:6];

  // Decoded view of the D instruction. A source register without a Tuse is
  // reported as register 0 so it can never match a producer.
  logic [4:0] w_dec_rs, w_dec_rt, w_dec_a3;
  logic [1:0] w_tuse_rs, w_tuse_rt, w_dec_tnew;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    w_dec_rs   = 5'd0;
    w_dec_rt   = 5'd0;
    w_dec_a3   = 5'd0;
    w_tuse_rs  = 2'd0;
    w_tuse_rt  = 2'd0;
    w_dec_tnew = 2'd0;
    unique case (w_op)
      6'b000000: begin
        unique case (w_funct)
          6'b100001, 6'b100011: begin             // addu, subu
            w_dec_rs = w_rs; w_tuse_rs = 2'd1;
            w_dec_rt = w_rt; w_tuse_rt = 2'd1;
            w_dec_a3 = w_rd; w_dec_tnew = 2'd1;
          end
          6'b001000: begin                        // jr
            w_dec_rs = w_rs; w_tuse_rs = 2'd0;
          end
          default: ;                              // nop, unknown
        endcase
      end
      6'b001101: begin                            // ori
        w_dec_rs = w_rs; w_tuse_rs = 2'd1;
        w_dec_a3 = w_rt; w_dec_tnew = 2'd1;
      end
      6'b001111: begin                            // lui
        w_dec_a3 = w_rt; w_dec_tnew = 2'd1;
      end
      6'b100011: begin                            // lw
        w_dec_rs = w_rs; w_tuse_rs = 2'd1;
        w_dec_a3 = w_rt; w_dec_tnew = 2'd2;
      end
      6'b101011: begin                            // sw
        w_dec_rs = w_rs; w_tuse_rs = 2'd1;
        w_dec_rt = w_rt; w_tuse_rt = 2'd2;
      end
      6'b000100: begin                            // beq
        w_dec_rs = w_rs; w_tuse_rs = 2'd0;
        w_dec_rt = w_rt; w_tuse_rt = 2'd0;
      end
      6'b000011: begin                            // jal
        w_dec_a3 = 5'd31; w_dec_tnew = 2'd0;
      end
      default: ;                                  // j, unknown
    endcase
  end

  // Shadow pipeline
  logic [4:0] r_rs_e, r_rt_e, r_a3_e, r_rt_m, r_a3_m, r_a3_w;
  logic [1:0] r_tnew_e, r_tnew_m;
  logic       w_stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its source, modelling real flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs_e   <= '0; r_rt_e <= '0; r_a3_e <= '0; r_tnew_e <= '0;
      r_rt_m   <= '0; r_a3_m <= '0; r_tnew_m <= '0;
      r_a3_w   <= '0;
    end else begin
      if (w_stall) begin
        r_rs_e <= '0; r_rt_e <= '0; r_a3_e <= '0; r_tnew_e <= '0;
      end else begin
        r_rs_e   <= w_dec_rs;
        r_rt_e   <= w_dec_rt;
        r_a3_e   <= w_dec_a3;
        r_tnew_e <= w_dec_tnew;
      end
      r_rt_m   <= r_rt_e;
      r_a3_m   <= r_a3_e;
      r_tnew_m <= (r_tnew_e == 2'd0) ? 2'd0 : r_tnew_e - 2'd1;
      r_a3_w   <= r_a3_m;
    end
  end

  // Nearest-producer stall check for one source register. W always has
  // Tnew 0, so only E and M can stall, but a W match never reaches here
  // while a nearer E or M match exists.
  function automatic logic src_stall(input logic [4:0] r, input logic [1:0] t);
    if (r == 5'd0)         return 1'b0;
    else if (r == r_a3_e)  return r_tnew_e > t;
    else if (r == r_a3_m)  return r_tnew_m > t;
    else                   return 1'b0;
  endfunction

  // D-stage select: nearest match only; a not-ready nearest match reads the
  // RF value and relies on the stall to retry.
  function automatic logic [1:0] d_sel(input logic [4:0] r);
    if (r == 5'd0)         return 2'd0;
    else if (r == r_a3_e)  return (r_tnew_e == 2'd0) ? 2'd1 : 2'd0;
    else if (r == r_a3_m)  return (r_tnew_m == 2'd0) ? 2'd2 : 2'd0;
    else if (r == r_a3_w)  return (W_FWD_D != 0) ? 2'd3 : 2'd0;
    else                   return 2'd0;
  endfunction

  function automatic logic [1:0] e_sel(input logic [4:0] r);
    if (r == 5'd0)                                return 2'd0;
    else if (r == r_a3_m && r_tnew_m == 2'd0)     return 2'd1;
    else if (r == r_a3_w)                         return 2'd2;
    else                                          return 2'd0;
  endfunction

  assign w_stall  = src_stall(w_dec_rs, w_tuse_rs) | src_stall(w_dec_rt, w_tuse_rt);
  assign stall    = w_stall;
  assign ir_e_clr = w_stall;
  assign fwd_rs_d = d_sel(w_dec_rs);
  assign fwd_rt_d = d_sel(w_dec_rt);
  assign fwd_rs_e = e_sel(r_rs_e);
  assign fwd_rt_e = e_sel(r_rt_e);
  assign fwd_rt_m = (r_rt_m != 5'd0) && (r_a3_w == r_rt_m);

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (reset)        r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
